// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : UART transmitter fed by a synchronous FIFO; frames are sent
//            back-to-back while words remain queued.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int ClockFrequencyHz = 66_000_000,
    parameter int BaudRate         = 9600,
    parameter int DataBits         = 8,
    parameter int Parity           = 0,
    parameter int StopBits         = 1,
    parameter int FifoDepth        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DataBits-1:0]         data,
    input  logic                        valid,
    output logic                        ready,
    output logic                        tx,
    output logic                        bsy,
    output logic [$clog2(FifoDepth):0]  level
);

    localparam int C_BIT_TIME = ClockFrequencyHz / BaudRate;
    localparam int C_CNT_W    = (C_BIT_TIME > 1) ? $clog2(C_BIT_TIME) : 1;
    localparam int C_ADDR_W   = $clog2(FifoDepth);
    localparam int C_PTR_W    = C_ADDR_W + 1;
    localparam int C_IDX_W    = $clog2(DataBits);

    localparam logic [C_CNT_W-1:0] C_CNT_RELOAD = C_CNT_W'(C_BIT_TIME - 1);
    localparam logic [C_IDX_W-1:0] C_LAST_DATA  = C_IDX_W'(DataBits - 1);
    localparam logic               C_LAST_STOP  = 1'(StopBits - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [C_IDX_W-1:0]   idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DataBits-1:0]  shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 bsy_q, bsy_d;
    logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    logic [DataBits-1:0]  mem_q [FifoDepth];

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_start_next;
    logic [DataBits-1:0]  w_head;
    logic                 w_head_par;
    logic [C_PTR_W-1:0]   w_level;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_level = wr_ptr_q - rd_ptr_q;
    assign w_full  = (wr_ptr_q[C_ADDR_W] != rd_ptr_q[C_ADDR_W]) &&
                     (wr_ptr_q[C_ADDR_W-1:0] == rd_ptr_q[C_ADDR_W-1:0]);
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_push  = valid && !w_full;
    assign w_head  = mem_q[rd_ptr_q[C_ADDR_W-1:0]];

    generate
        if (Parity == 1) begin : g_parity_odd
            assign w_head_par = ~^w_head;
        end else if (Parity == 2) begin : g_parity_even
            assign w_head_par = ^w_head;
        end else begin : g_parity_none
            assign w_head_par = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        stop_d       = stop_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tx_d         = tx_q;
        bsy_d        = bsy_q;
        w_pop        = 1'b0;
        w_start_next = 1'b0;
        w_bit_end    = (cnt_q == '0);

        case (state_q)
            ST_IDLE: begin
                tx_d  = 1'b1;
                bsy_d = 1'b0;
                if (!w_empty) begin
                    w_start_next = 1'b1;
                end
            end

            ST_START: begin
                if (w_bit_end) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                    cnt_d   = C_CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (w_bit_end) begin
                    cnt_d = C_CNT_RELOAD;
                    if (idx_q == C_LAST_DATA) begin
                        if (Parity != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                            stop_d  = 1'b0;
                        end
                    end else begin
                        // Next bit is taken before the shift so tx stays registered.
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + C_IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end

            ST_PARITY: begin
                if (w_bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    cnt_d   = C_CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (w_bit_end) begin
                    if (stop_q == C_LAST_STOP) begin
                        if (!w_empty) begin
                            w_start_next = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                            bsy_d   = 1'b0;
                        end
                    end else begin
                        stop_d = 1'b1;
                        cnt_d  = C_CNT_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                bsy_d   = 1'b0;
            end
        endcase

        // Popping latches the word and its parity, so later pushes cannot disturb it.
        if (w_start_next) begin
            w_pop   = 1'b1;
            shift_d = w_head;
            par_d   = w_head_par;
            tx_d    = 1'b0;
            bsy_d   = 1'b1;
            cnt_d   = C_CNT_RELOAD;
            state_d = ST_START;
        end

        wr_ptr_d = wr_ptr_q + C_PTR_W'(w_push);
        rd_ptr_d = rd_ptr_q + C_PTR_W'(w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            bsy_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            bsy_q    <= bsy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[C_ADDR_W-1:0]] <= data;
        end
    end

    assign ready = !w_full;
    assign tx    = tx_q;
    assign bsy   = bsy_q;
    assign level = w_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo (8N1 and 7E2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int BT    = 10;
    localparam int DEPTH = 4;
    localparam int A_DB = 8, A_PAR = 0, A_SB = 1;
    localparam int B_DB = 7, B_PAR = 2, B_SB = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_a = '0;
    logic       valid_a = 1'b0;
    logic       ready_a, tx_a, bsy_a;
    logic [2:0] level_a;
    logic [6:0] data_b = '0;
    logic       valid_b = 1'b0;
    logic       ready_b, tx_b, bsy_b;
    logic [2:0] level_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .ClockFrequencyHz(40), .BaudRate(4), .DataBits(A_DB),
        .Parity(A_PAR), .StopBits(A_SB), .FifoDepth(DEPTH)
    ) dut_a (
        .clk(clk), .rst(rst), .data(data_a), .valid(valid_a),
        .ready(ready_a), .tx(tx_a), .bsy(bsy_a), .level(level_a)
    );

    uart_tx_fifo #(
        .ClockFrequencyHz(40), .BaudRate(4), .DataBits(B_DB),
        .Parity(B_PAR), .StopBits(B_SB), .FifoDepth(DEPTH)
    ) dut_b (
        .clk(clk), .rst(rst), .data(data_b), .valid(valid_b),
        .ready(ready_b), .tx(tx_b), .bsy(bsy_b), .level(level_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic tx_of(input int k);
        return (k == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic bsy_of(input int k);
        return (k == 0) ? bsy_a : bsy_b;
    endfunction

    task automatic drive(input int k, input logic v, input logic [8:0] w);
        if (k == 0) begin
            valid_a = v;
            data_a  = w[7:0];
        end else begin
            valid_b = v;
            data_b  = w[6:0];
        end
    endtask

    // ---------------- reference model: word queue + frame timeline ----------
    logic [8:0]  mq0[$];
    logic [8:0]  mq1[$];
    logic        m_busy[2];
    int          m_t[2];
    int          m_len[2];
    logic [11:0] m_bits[2];

    function automatic int qsize(input int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic void build_frame(input int k, input logic [8:0] w,
                                        output logic [11:0] bits, output int n);
        int db, par, sb, ones;
        db   = (k == 0) ? A_DB  : B_DB;
        par  = (k == 0) ? A_PAR : B_PAR;
        sb   = (k == 0) ? A_SB  : B_SB;
        bits = '1;
        ones = 0;
        n    = 0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < db; i++) begin
            bits[n] = w[i];
            ones += w[i] ? 1 : 0;
            n++;
        end
        if (par == 1) begin
            bits[n] = (ones % 2 == 0);
            n++;
        end else if (par == 2) begin
            bits[n] = (ones % 2 == 1);
            n++;
        end
        n += sb;
    endfunction

    task automatic model_step(input int k);
        int         pre;
        logic       rdy;
        logic [8:0] w;
        logic       v;
        logic [8:0] d;
        pre = qsize(k);
        rdy = (pre < DEPTH);
        v   = (k == 0) ? valid_a : valid_b;
        d   = (k == 0) ? {1'b0, data_a} : {2'b00, data_b};
        if (m_busy[k]) begin
            m_t[k]++;
            if (m_t[k] == m_len[k] * BT) m_busy[k] = 1'b0;
        end
        if (!m_busy[k] && pre > 0) begin
            if (k == 0) w = mq0.pop_front();
            else        w = mq1.pop_front();
            build_frame(k, w, m_bits[k], m_len[k]);
            m_busy[k] = 1'b1;
            m_t[k]    = 0;
        end
        if (v && rdy) begin
            if (k == 0) mq0.push_back(d);
            else        mq1.push_back(d);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq0.delete();
            mq1.delete();
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 1'b0;
                m_t[k]    = 0;
                m_len[k]  = 0;
                m_bits[k] = '1;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    function automatic logic exp_tx(input int k);
        if (!m_busy[k]) return 1'b1;
        return m_bits[k][m_t[k] / BT];
    endfunction

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            check("mdl_a_tx",    tx_a,    exp_tx(0));
            check("mdl_a_bsy",   bsy_a,   m_busy[0]);
            check("mdl_a_level", level_a, qsize(0));
            check("mdl_a_ready", ready_a, qsize(0) < DEPTH);
            check("mdl_b_tx",    tx_b,    exp_tx(1));
            check("mdl_b_bsy",   bsy_b,   m_busy[1]);
            check("mdl_b_level", level_b, qsize(1));
            check("mdl_b_ready", ready_b, qsize(1) < DEPTH);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bsy_a || bsy_b || level_a != 0 || level_b != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", n < 3000, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int         sel;
        logic [8:0] word;
        logic [11:0] bits;
        int         nbits;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         hi;
        logic       etx, ebsy;
        logic [7:0] wv[6];
        logic [7:0] rxw[5];
        int         f, r, rate;

        vecs[0] = '{0, 9'h0A5, 12'b00_1_10100101_0, 10};
        vecs[1] = '{0, 9'h000, 12'b00_1_00000000_0, 10};
        vecs[2] = '{0, 9'h0FF, 12'b00_1_11111111_0, 10};
        vecs[3] = '{0, 9'h03C, 12'b00_1_00111100_0, 10};
        vecs[4] = '{1, 9'h007, 12'b0_11_1_0000111_0, 11};
        vecs[5] = '{1, 9'h055, 12'b0_11_0_1010101_0, 11};

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_a_tx", tx_a, 1'b1);
        check("rst_a_bsy", bsy_a, 1'b0);
        check("rst_a_ready", ready_a, 1'b1);
        check("rst_a_level", level_a, 0);
        check("rst_b_tx", tx_b, 1'b1);
        check("rst_b_bsy", bsy_b, 1'b0);
        check("rst_b_ready", ready_b, 1'b1);
        check("rst_b_level", level_b, 0);
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single-frame vectors: tx and bsy checked every cycle of the frame.
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            drive(vecs[i].sel, 1'b1, vecs[i].word);
            @(negedge clk);
            drive(vecs[i].sel, 1'b0, 9'h0);
            hi = 0;
            for (int c = 1; c <= vecs[i].nbits * BT + 5; c++) begin
                @(negedge clk);
                ebsy = (c <= vecs[i].nbits * BT);
                etx  = ebsy ? vecs[i].bits[(c - 1) / BT] : 1'b1;
                check($sformatf("vec%0d_tx_c%0d", i, c), tx_of(vecs[i].sel), etx);
                check($sformatf("vec%0d_bsy_c%0d", i, c), bsy_of(vecs[i].sel), ebsy);
                hi += bsy_of(vecs[i].sel) ? 1 : 0;
            end
            check($sformatf("vec%0d_bsy_len", i), hi, vecs[i].nbits * BT);
        end

        // Back-to-back frames with no idle gap.
        wait_idle();
        drive(0, 1'b1, 9'h000);
        @(negedge clk);
        drive(0, 1'b1, 9'h0FF);
        @(negedge clk);
        drive(0, 1'b0, 9'h0);
        hi = 0;
        for (int c = 1; c <= 205; c++) begin
            hi += bsy_a ? 1 : 0;
            if (c == 1 || c == 50 || c == 100) check("b2b_level_first", level_a, 1);
            if (c == 100) check("b2b_last_stop", tx_a, 1'b1);
            if (c == 101) begin
                check("b2b_second_start", tx_a, 1'b0);
                check("b2b_level_second", level_a, 0);
            end
            @(negedge clk);
        end
        check("b2b_bsy_len", hi, 200);

        // Overfill: six words with valid held high, the sixth is dropped.
        wait_idle();
        for (int k = 0; k < 6; k++) wv[k] = 8'($urandom_range(0, 255));
        drive(0, 1'b1, {1'b0, wv[0]});
        for (int c = 0; c <= 520; c++) begin
            @(negedge clk);
            if (c < 5) drive(0, 1'b1, {1'b0, wv[c + 1]});
            else if (c == 5) drive(0, 1'b0, 9'h0);
            if (c == 4 || c == 5 || c == 100) begin
                check($sformatf("full_ready_c%0d", c), ready_a, 1'b0);
                check($sformatf("full_level_c%0d", c), level_a, 4);
            end
            if (c == 101) begin
                check("full_ready_rise", ready_a, 1'b1);
                check("full_level_after_pop", level_a, 3);
            end
            if (c >= 1 && c <= 500) begin
                f = (c - 1) / 100;
                r = (c - 1) % 100;
                if (r % BT == 5 && r / BT >= 1 && r / BT <= 8) rxw[f][r / BT - 1] = tx_a;
            end
        end
        for (int k = 0; k < 5; k++) check($sformatf("full_order_w%0d", k), rxw[k], wv[k]);
        check("full_drained_bsy", bsy_a, 1'b0);
        check("full_drained_level", level_a, 0);

        // Reset during the fourth data bit with two words queued.
        wait_idle();
        drive(0, 1'b1, 9'h05A);
        @(negedge clk);
        drive(0, 1'b1, 9'h033);
        @(negedge clk);
        drive(0, 1'b1, 9'h0C3);
        @(negedge clk);
        drive(0, 1'b0, 9'h0);
        repeat (43) @(negedge clk);
        check("mid_pre_level", level_a, 2);
        check("mid_pre_bsy", bsy_a, 1'b1);
        check("mid_pre_tx_d3", tx_a, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx", tx_a, 1'b1);
        check("mid_rst_bsy", bsy_a, 1'b0);
        check("mid_rst_level", level_a, 0);
        check("mid_rst_ready", ready_a, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        hi = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            hi += (bsy_a || !tx_a || level_a != 0) ? 1 : 0;
        end
        check("mid_no_restart", hi, 0);
        drive(0, 1'b1, 9'h081);
        @(negedge clk);
        drive(0, 1'b0, 9'h0);
        @(negedge clk);
        check("mid_new_push_start", tx_a, 1'b0);

        // Randomised traffic alternating between dense and sparse phases.
        wait_idle();
        for (int i = 0; i < 4000; i++) begin
            rate = ((i / 1000) % 2 == 0) ? 4 : 150;
            drive(0, $urandom_range(0, rate - 1) == 0, 9'($urandom));
            drive(1, $urandom_range(0, rate - 1) == 0, 9'($urandom));
            @(negedge clk);
        end
        drive(0, 1'b0, 9'h0);
        drive(1, 1'b0, 9'h0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual running required finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
